// File: rtl/seg_display_reader.sv
// Reads a multiplexed two-digit 7-segment display: synchronizes the drive lines,
// waits for each digit pattern to settle, then assembles tens/units into a BCD and binary value.
module seg_display_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit,
  input  logic [6:0] segments,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] value,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_count
);
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      LOCK_AT  = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0]      STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic {HUNT, HAVE_TENS} state_t;

  // Returns {ok, bcd}; a blank digit is only meaningful as a suppressed leading zero.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic allow_blank);
    case (seg)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      7'h00:   return {allow_blank, 4'd0};
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
    return ({3'b000, t} * 7'd10) + {3'b000, u};
  endfunction

  logic [7:0]    sync1_q, sync2_q, prev_q;
  logic [3:0]    stab_q, stab_d;
  logic [TW-1:0] to_q, to_d;
  state_t        state_q, state_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [6:0]    value_q, value_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [7:0]    errcnt_q, errcnt_d;

  logic       match, lock, samp_digit, timeout_hit;
  logic [4:0] tens_dec, units_dec;

  assign match       = (sync2_q == prev_q);
  assign lock        = match && (stab_q == LOCK_AT);
  assign samp_digit  = sync2_q[7];
  assign tens_dec    = seg_decode(sync2_q[6:0], 1'b1);
  assign units_dec   = seg_decode(sync2_q[6:0], 1'b0);
  assign timeout_hit = (state_q == HAVE_TENS) && !lock && (to_q == TO_LAST);

  always_comb begin
    stab_d = stab_q;
    if (!match)                 stab_d = 4'd0;
    else if (stab_q != STAB_MAX) stab_d = stab_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      stab_q   <= '0;
      to_q     <= '0;
      state_q  <= HUNT;
      pend_q   <= '0;
      tens_q   <= '0;
      units_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      sync1_q  <= {digit, segments};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stab_q   <= stab_d;
      to_q     <= to_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:      if (lock && samp_digit && tens_dec[4]) state_d = HAVE_TENS;
      HAVE_TENS: begin
        if (lock) begin
          if (!samp_digit || !tens_dec[4]) state_d = HUNT;
        end else if (timeout_hit) begin
          state_d = HUNT;
        end
      end
      default:   state_d = HUNT;
    endcase
  end

  // A lock always wins over a coincident timeout, so valid and err stay exclusive.
  always_comb begin
    pend_d  = pend_q;
    tens_d  = tens_q;
    units_d = units_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    to_d    = '0;
    case (state_q)
      HUNT: begin
        if (lock && samp_digit) begin
          if (tens_dec[4]) pend_d = tens_dec[3:0];
          else             err_d  = 1'b1;
        end
      end
      HAVE_TENS: begin
        to_d = to_q + 1'b1;
        if (lock) begin
          if (samp_digit) begin
            if (tens_dec[4]) begin
              pend_d = tens_dec[3:0];
              to_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (units_dec[4]) begin
            tens_d  = pend_q;
            units_d = units_dec[3:0];
            value_d = bcd_to_bin(pend_q, units_dec[3:0]);
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    errcnt_d = (err_d && errcnt_q != 8'hFF) ? errcnt_q + 8'd1 : errcnt_q;
  end

  assign tens      = tens_q;
  assign units     = units_q;
  assign value     = value_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_count = errcnt_q;
endmodule

// File: tb/tb_seg_display_reader.sv
// Bench for seg_display_reader: frame table plus hand-built timeout, reset and saturation sequences,
// with every valid/err pulse matched against a queue of expected events including their cycle.
module tb_seg_display_reader;
  localparam int STABLE_CYCLES = 4;
  localparam int TIMEOUT       = 4096;
  localparam int LAT           = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       digit = 1'b0;
  logic [6:0] segments = 7'h00;
  logic [3:0] tens, units;
  logic [6:0] value;
  logic       valid, err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  seg_display_reader #(.STABLE_CYCLES(STABLE_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .digit(digit), .segments(segments),
    .tens(tens), .units(units), .value(value),
    .valid(valid), .err(err), .err_count(err_count)
  );

  typedef struct {
    bit         is_err;
    logic [3:0] t;
    logic [3:0] u;
    logic [6:0] v;
    logic [7:0] ec;
    int         at;
  } exp_t;

  // kind: 0 = valid frame, 1 = err on tens lock, 2 = err on units lock
  typedef struct {
    logic [6:0] tp;
    logic [6:0] up;
    int         kind;
    logic [3:0] t;
    logic [3:0] u;
    logic [6:0] v;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  logic [3:0] m_t = 4'd0, m_u = 4'd0;
  logic [6:0] m_v = 7'd0;
  logic [7:0] m_ec = 8'd0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (!(valid || err)) return;
    if (valid && err) chk("valid_err_exclusive", 1, 0);
    if (sb.size() == 0) begin
      chk(valid ? "unexpected_valid" : "unexpected_err", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("event_is_err", int'(err), int'(e.is_err));
    chk("tens", int'(tens), int'(e.t));
    chk("units", int'(units), int'(e.u));
    chk("value", int'(value), int'(e.v));
    chk("err_count", int'(err_count), int'(e.ec));
    chk("event_cycle", cyc_n, e.at);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    observe();
  endtask

  task automatic hold(input logic d, input logic [6:0] seg, input int n);
    digit    = d;
    segments = seg;
    repeat (n) tick();
  endtask

  task automatic push_valid(input logic [3:0] t, input logic [3:0] u, input logic [6:0] v, input int at);
    m_t = t; m_u = u; m_v = v;
    sb.push_back('{1'b0, t, u, v, m_ec, at});
  endtask

  task automatic push_err(input int at);
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    sb.push_back('{1'b1, m_t, m_u, m_v, m_ec, at});
  endtask

  task automatic frame(input vec_t f);
    if (f.kind == 1) push_err(cyc_n + LAT);
    hold(1'b1, f.tp, 10);
    if (f.kind == 0)      push_valid(f.t, f.u, f.v, cyc_n + LAT);
    else if (f.kind == 2) push_err(cyc_n + LAT);
    hold(1'b0, f.up, 10);
  endtask

  initial begin
    vec_t f;
    vecs[0]  = '{7'h4F, 7'h6D, 0, 4'd3, 4'd5, 7'd35};
    vecs[1]  = '{7'h00, 7'h06, 0, 4'd0, 4'd1, 7'd1};
    vecs[2]  = '{7'h00, 7'h00, 2, 4'd0, 4'd0, 7'd0};
    vecs[3]  = '{7'h7F, 7'h6F, 0, 4'd8, 4'd9, 7'd89};
    vecs[4]  = '{7'h3F, 7'h3F, 0, 4'd0, 4'd0, 7'd0};
    vecs[5]  = '{7'h01, 7'h06, 1, 4'd0, 4'd0, 7'd0};
    vecs[6]  = '{7'h6D, 7'h07, 0, 4'd5, 4'd7, 7'd57};
    vecs[7]  = '{7'h66, 7'h7D, 0, 4'd4, 4'd6, 7'd46};
    vecs[8]  = '{7'h5B, 7'h5B, 0, 4'd2, 4'd2, 7'd22};
    vecs[9]  = '{7'h07, 7'h7F, 0, 4'd7, 4'd8, 7'd78};
    vecs[10] = '{7'h7D, 7'h12, 2, 4'd0, 4'd0, 7'd0};
    vecs[11] = '{7'h06, 7'h66, 0, 4'd1, 4'd4, 7'd14};

    repeat (3) tick();
    chk("rst_tens", int'(tens), 0);
    chk("rst_units", int'(units), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_count", int'(err_count), 0);
    rst_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 12; i++) frame(vecs[i]);

    // Patterns that never settle long enough must stay silent; a stray tens lock would make the blank units err.
    for (int k = 0; k < 8; k++) hold(1'b1, (k % 2 == 0) ? 7'h4F : 7'h06, 3);
    hold(1'b0, 7'h00, 10);

    push_err(cyc_n + LAT + TIMEOUT);
    hold(1'b1, 7'h7F, TIMEOUT + 20);
    hold(1'b0, 7'h3F, 10);
    f = '{7'h5B, 7'h4F, 0, 4'd2, 4'd3, 7'd23};
    frame(f);

    hold(1'b1, 7'h66, 10);
    digit = 1'b0; segments = 7'h6D;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tens", int'(tens), 0);
    chk("midrst_units", int'(units), 0);
    chk("midrst_value", int'(value), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_err_count", int'(err_count), 0);
    m_t = 4'd0; m_u = 4'd0; m_v = 7'd0; m_ec = 8'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();

    for (int k = 0; k < 300; k++) begin
      push_err(cyc_n + LAT);
      hold(1'b1, 7'h01, 10);
      hold(1'b0, 7'h00, 10);
    end
    chk("err_count_saturated", int'(err_count), 255);
    f = '{7'h6F, 7'h3F, 0, 4'd9, 4'd0, 7'd90};
    frame(f);

    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seg_display_reader.md
SEG_DISPLAY_READER -- requirements
Module: seg_display_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a digit pattern (legal range 2..15).
REQ-002 Parameter: TIMEOUT, 4096, cycles allowed in HAVE_TENS without a units acceptance before abandoning the frame.
REQ-003 Port: clk  input  1  system clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: digit  input  1  display digit select; 1 = tens digit shown, 0 = units digit shown.
REQ-006 Port: segments  input  7  segment drive, active high; bit0=a ... bit6=g.
REQ-007 Port: tens  output  4  last accepted tens digit, BCD.
REQ-008 Port: units  output  4  last accepted units digit, BCD.
REQ-009 Port: value  output  7  binary tens*10+units of last accepted frame, range 0..99.
REQ-010 Port: valid  output  1  one-cycle pulse when tens/units/value update.
REQ-011 Port: err  output  1  one-cycle pulse on undecodable pattern or timeout.
REQ-012 Port: err_count  output  8  saturating count of err pulses.

Function
REQ-013 digit and segments SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A prev register SHALL hold the previous synchronized {digit,segments}; match = synchronized sample equals prev.
REQ-015 Stability counter SHALL clear to 0 on mismatch, increment on match, saturate at STABLE_CYCLES.
REQ-016 lock SHALL be asserted for exactly one cycle: match and counter == STABLE_CYCLES-1; a steady pattern produces no further lock until a mismatch occurs.
REQ-017 Decode table SHALL be: 0=0x3F,1=0x06,2=0x5B,3=0x4F,4=0x66,5=0x6D,6=0x7D,7=0x07,8=0x7F,9=0x6F; blank 0x00 decodes as 0 for tens only; all other patterns are invalid.
REQ-018 FSM SHALL have states HUNT and HAVE_TENS.
REQ-019 HUNT, lock, digit=1, valid pattern: store pending tens, go HAVE_TENS.
REQ-020 HUNT, lock, digit=1, invalid pattern: err pulse, stay HUNT.
REQ-021 HUNT, lock, digit=0: ignored, no err, stay HUNT.
REQ-022 HAVE_TENS, lock, digit=1: valid overwrites pending tens and stays; invalid gives err and goes HUNT.
REQ-023 HAVE_TENS, lock, digit=0, valid: tens/units/value update and valid pulses in the following cycle; go HUNT.
REQ-024 HAVE_TENS, lock, digit=0, invalid: err pulse, outputs unchanged, go HUNT.
REQ-025 Timeout counter SHALL clear on entry to HAVE_TENS and on each tens re-store; reaching TIMEOUT gives err pulse and goes HUNT.
REQ-026 Lock and timeout in the same cycle: lock SHALL take precedence; no timeout err.
REQ-027 valid and err SHALL never be high in the same cycle.
REQ-028 tens, units, value SHALL hold between valid pulses.
REQ-029 err_count SHALL increment once per err pulse and saturate at 255.
REQ-030 Latency: new pattern captured by first sync flop at edge 0 -> lock at edge 2+STABLE_CYCLES -> valid high after that edge for one cycle.

Reset
REQ-031 rst_n low SHALL immediately clear sync flops, prev, counters, pending tens, tens, units, value, valid, err, err_count to 0 and force HUNT.
REQ-032 Reset mid-frame SHALL discard pending tens; no valid or err is produced for the interrupted frame.

Verification
REQ-033 Stable tens 0x4F (3) for 10 cycles, then units 0x6D (5) for 10 cycles, STABLE_CYCLES=4 -> valid once, 6 edges after units capture; tens=3, units=5, value=35.
REQ-034 Tens 0x00, units 0x06 -> value=1; units 0x00 -> err, err_count=1, value unchanged.
REQ-035 Pattern toggling every 3 cycles with STABLE_CYCLES=4 -> no lock, no valid, no err.
REQ-036 Tens 0x7F, then no units for TIMEOUT cycles -> single err, state HUNT; next full frame still yields valid.
REQ-037 Tens 0x66 accepted, rst_n pulsed low mid units -> all outputs 0 immediately; after release, a units-only pattern produces no valid.
REQ-038 300 invalid tens patterns (0x01), each stable 10 cycles -> err_count saturates at 255.
